// File: rtl/acia_rx_fifo_if.sv
// Read-side bundle between the ACIA receive FIFO (slave) and the register file (master).
// The register file pops with rd_stb and watches the head entry and the status flags.
interface acia_rx_fifo_if #(
  parameter int FAW = 4
);
  logic           rd_stb;
  logic [7:0]     rd_dat;
  logic           rd_fe;
  logic           rd_pe;
  logic           rd_valid;
  logic [FAW:0]   fifo_cnt;
  logic           ovr;
  logic           brk;

  modport master (
    output rd_stb,
    input  rd_dat, rd_fe, rd_pe, rd_valid, fifo_cnt, ovr, brk
  );

  modport slave (
    input  rd_stb,
    output rd_dat, rd_fe, rd_pe, rd_valid, fifo_cnt, ovr, brk
  );
endinterface

// File: rtl/acia_rx_fifo.sv
// ACIA serial receiver: synchroniser, glitch filter, 5-8 data bit framing, break detect and an
// error-tagged receive FIFO. Parity checking is built only when ACIA_RXF_PARITY_EN is defined.
module acia_rx_fifo #(
  parameter int SCW = 16,
  parameter int FAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_serial,
  input  logic [SCW-1:0] baud_div,
  input  logic [1:0]     data_bits,
  input  logic           parity_en,
  input  logic           parity_odd,
  acia_rx_fifo_if.slave  rd
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] dat;
  } entry_t;

  localparam logic [FAW:0] DEPTH = (FAW + 1)'(1) << FAW;

  // ---------------------------------------------------------------------------
  // Input synchroniser and 4-sample hysteresis filter
  // ---------------------------------------------------------------------------
  logic       r_sync1;
  logic       r_sync2;
  logic       r_line;
  logic [1:0] r_fcnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_line  <= 1'b1;
      r_fcnt  <= 2'd0;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_line) begin
        r_fcnt <= 2'd0;
      end else if (r_fcnt == 2'd3) begin
        r_line <= r_sync2;
        r_fcnt <= 2'd0;
      end else begin
        r_fcnt <= r_fcnt + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t         r_state;
  logic [SCW-1:0] r_rcnt;
  logic [2:0]     r_bidx;
  logic [2:0]     r_last;
  logic [7:0]     r_shift;
  logic           r_armed;
  logic           r_brk;

  logic w_sample;
  logic w_push;
  logic w_push_pe;
  logic w_to_parity;
  logic w_brk_frame;

  assign w_sample = (r_rcnt == '0);
  assign w_push   = (r_state == ST_STOP) && w_sample;

`ifdef ACIA_RXF_PARITY_EN
  logic r_cfg_par;
  logic r_cfg_odd;
  logic r_pbit;
  logic r_pe;

  assign w_to_parity = r_cfg_par;
  assign w_push_pe   = r_pe;
  assign w_brk_frame = (r_shift == 8'd0) && !r_line && !(r_cfg_par && r_pbit);
`else
  logic w_unused_parity_cfg;

  assign w_unused_parity_cfg = parity_en ^ parity_odd;
  assign w_to_parity = 1'b0;
  assign w_push_pe   = 1'b0;
  assign w_brk_frame = (r_shift == 8'd0) && !r_line;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
      r_bidx  <= 3'd0;
      r_last  <= 3'd7;
      r_shift <= 8'd0;
      r_armed <= 1'b0;
      r_brk   <= 1'b0;
`ifdef ACIA_RXF_PARITY_EN
      r_cfg_par <= 1'b0;
      r_cfg_odd <= 1'b0;
      r_pbit    <= 1'b0;
      r_pe      <= 1'b0;
`endif
    end else begin
      r_brk <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A frame may only start after the line has been seen idle high.
          if (r_line) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= ST_START;
            r_rcnt  <= baud_div >> 1;
            r_last  <= 3'd4 + {1'b0, data_bits};
            r_shift <= 8'd0;
            r_bidx  <= 3'd0;
`ifdef ACIA_RXF_PARITY_EN
            r_cfg_par <= parity_en;
            r_cfg_odd <= parity_odd;
            r_pbit    <= 1'b0;
            r_pe      <= 1'b0;
`endif
          end
        end

        ST_START: begin
          if (w_sample) begin
            r_rcnt  <= baud_div;
            r_state <= r_line ? ST_IDLE : ST_DATA;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end

        ST_DATA: begin
          if (w_sample) begin
            r_rcnt          <= baud_div;
            r_shift[r_bidx] <= r_line;
            r_bidx          <= r_bidx + 3'd1;
            if (r_bidx == r_last) begin
              r_state <= w_to_parity ? ST_PARITY : ST_STOP;
            end
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end

`ifdef ACIA_RXF_PARITY_EN
        ST_PARITY: begin
          if (w_sample) begin
            r_rcnt  <= baud_div;
            r_pbit  <= r_line;
            r_pe    <= ((^r_shift) ^ r_line) != r_cfg_odd;
            r_state <= ST_STOP;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (w_sample) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_brk   <= w_brk_frame;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  entry_t         r_mem [1 << FAW];
  logic [FAW-1:0] r_wptr;
  logic [FAW-1:0] r_rptr;
  logic [FAW:0]   r_cnt;
  logic           r_ovr;

  logic   w_empty;
  logic   w_full;
  logic   w_pop;
  logic   w_wr;
  entry_t w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == DEPTH);
  assign w_pop   = rd.rd_stb && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = w_push && (!w_full || w_pop);

  // NOTE: storage has no reset; pointers and count define what is valid, and outputs are gated.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= '{pe: w_push_pe, fe: !r_line, dat: r_shift};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_ovr <= 1'b1;
      end else if (w_pop) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rptr];

  assign rd.rd_dat   = w_head.dat;
  assign rd.rd_fe    = w_head.fe;
  assign rd.rd_pe    = w_head.pe;
  assign rd.rd_valid = !w_empty;
  assign rd.fifo_cnt = r_cnt;
  assign rd.ovr      = r_ovr;
  assign rd.brk      = r_brk;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Bench for acia_rx_fifo: serial frames driven bit by bit, checked against a queue-based model
// of frame decoding and FIFO/overrun rules. Follows ACIA_RXF_PARITY_EN like the design.
module tb_acia_rx_fifo;
  localparam int SCW   = 16;
  localparam int FAW   = 2;
  localparam int DEPTH = 1 << FAW;
`ifdef ACIA_RXF_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] dat;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rx  = 1'b1;
  logic [SCW-1:0] baud = 16'd138;
  logic [1:0]     dbits = 2'd3;
  logic           par_en = 1'b0;
  logic           par_odd = 1'b0;

  acia_rx_fifo_if #(.FAW(FAW)) rd_if ();

  acia_rx_fifo #(.SCW(SCW), .FAW(FAW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx),
    .baud_div   (baud),
    .data_bits  (dbits),
    .parity_en  (par_en),
    .parity_odd (par_odd),
    .rd         (rd_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int brk_seen = 0;
  always @(negedge clk) if (rd_if.brk === 1'b1) brk_seen <= brk_seen + 1;

  ent_t exp_q[$];
  bit   exp_ovr = 1'b0;
  int   exp_brk = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t0 = 0;
  int   off = 0;
  bit   found = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one serial frame on rx followed by an idle-high gap.
  task automatic frame_tx(input logic [7:0] d, input int nb, input bit par, input bit pbit,
                          input bit stopb);
    int bt;
    bt = int'(baud) + 1;
    rx = 1'b0;
    tick(bt);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      tick(bt);
    end
    if (par) begin
      rx = pbit;
      tick(bt);
    end
    rx = stopb;
    tick(bt);
    rx = 1'b1;
    tick(2 * bt + 10);
  endtask

  // Reference: decode the frame from its bit-level description and apply FIFO rules.
  task automatic model_frame(input logic [7:0] d, input int nb, input bit par, input bit odd,
                             input bit pbit, input bit stopb, input bit pop_same);
    ent_t e;
    e.dat = d & 8'((1 << nb) - 1);
    e.fe  = !stopb;
    e.pe  = par ? ((($countones(e.dat) + int'(pbit)) % 2) != int'(odd)) : 1'b0;
    if (e.dat == 8'd0 && !(par && pbit) && !stopb) exp_brk++;
    if (pop_same && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ovr = 1'b0;
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovr = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input int nb, input bit par_req, input bit odd,
                       input bit pbit, input bit stopb);
    bit par;
    par     = par_req && PAR_BUILT;
    dbits   = 2'(nb - 5);
    par_en  = par_req;
    par_odd = odd;
    frame_tx(d, nb, par, pbit, stopb);
    model_frame(d, nb, par, odd, pbit, stopb, 1'b0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cnt"},   32'(rd_if.fifo_cnt), exp_q.size());
    check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'(exp_q.size() != 0));
    check({tag, "_ovr"},   32'(rd_if.ovr),      32'(exp_ovr));
    check({tag, "_brk"},   brk_seen,            exp_brk);
  endtask

  task automatic pop_check(input string tag);
    ent_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, 32'(rd_if.rd_valid), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_dat"}, 32'(rd_if.rd_dat), 32'(e.dat));
    check({tag, "_fe"},  32'(rd_if.rd_fe),  32'(e.fe));
    check({tag, "_pe"},  32'(rd_if.rd_pe),  32'(e.pe));
    rd_if.rd_stb = 1'b1;
    tick(1);
    rd_if.rd_stb = 1'b0;
    exp_ovr = 1'b0;
    check({tag, "_cnt_after"}, 32'(rd_if.fifo_cnt), exp_q.size());
    check({tag, "_ovr_after"}, 32'(rd_if.ovr),      32'(exp_ovr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd0);
    check({tag, "_cnt"},   32'(rd_if.fifo_cnt), 32'd0);
    check({tag, "_ovr"},   32'(rd_if.ovr),      32'd0);
    check({tag, "_brk"},   32'(rd_if.brk),      32'd0);
    check({tag, "_dat"},   32'(rd_if.rd_dat),   32'd0);
    check({tag, "_fe"},    32'(rd_if.rd_fe),    32'd0);
    check({tag, "_pe"},    32'(rd_if.rd_pe),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         nb;
    bit         pr, od, pb, sb;

    rd_if.rd_stb = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("reset");

    // 8N1 0xA5 at 115200 @ 16 MHz
    baud = 16'd138;
    frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("a5");
    pop_check("a5_pop");
    check_status("a5_drained");

    // 5 data bits, even parity, deliberately wrong parity bit
    frame(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_status("par5");
    pop_check("par5_pop");

    // Stop bit low on non-zero data: framing error, no break
    frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("fe");
    pop_check("fe_pop");

    // Line held low for 20 bit times: exactly one break entry
    dbits  = 2'd3;
    par_en = 1'b0;
    rx = 1'b0;
    tick(20 * (int'(baud) + 1));
    rx = 1'b1;
    tick(3 * (int'(baud) + 1));
    model_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("break");
    pop_check("break_pop");

    // Short glitch, then a low pulse shorter than half a bit
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(int'(baud) + 1);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(3 * (int'(baud) + 1));
    check_status("glitch");

    // Overrun: five frames into a four-entry FIFO; first frame measures push latency
    baud  = 16'd20;
    dbits = 2'd3;
    par_en = 1'b0;
    t0    = cyc;
    found = 1'b0;
    fork
      frame_tx(8'h01, 8, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 12 * (int'(baud) + 1); k++) begin
          @(negedge clk);
          if (!found && rd_if.fifo_cnt == 3'd1) begin
            found = 1'b1;
            off   = cyc - t0;
          end
        end
      end
    join
    model_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("push_seen", 32'(found), 32'd1);
    for (int i = 2; i <= 5; i++) frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("ovr");
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");

    // Full FIFO with a pop on the push edge: no overrun, count stays at depth
    for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("full");
    d  = 8'($urandom);
    t0 = cyc;
    fork
      frame_tx(d, 8, 1'b0, 1'b0, 1'b1);
      begin
        if (found) begin
          while (cyc < t0 + off - 1) @(negedge clk);
          rd_if.rd_stb = 1'b1;
          @(negedge clk);
          rd_if.rd_stb = 1'b0;
        end
      end
    join
    model_frame(d, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_status("pushpop");
    for (int i = 0; i < DEPTH; i++) pop_check("pushpop_pop");

    // Randomised frames: formats, parity, stop errors and read timing
    for (int f = 0; f < 12; f++) begin
      baud = 16'($urandom_range(15, 30));
      d    = 8'($urandom);
      nb   = $urandom_range(5, 8);
      pr   = 1'($urandom_range(0, 1));
      od   = 1'($urandom_range(0, 1));
      pb   = 1'($urandom_range(0, 1));
      sb   = ($urandom_range(0, 4) != 0);
      frame(d, nb, pr, od, pb, sb);
      check_status("rnd");
      if ($urandom_range(0, 2) == 0) pop_check("rnd_pop");
    end
    while (exp_q.size() > 0) pop_check("rnd_drain");

    // Reset in the middle of a frame discards it and clears the FIFO
    baud = 16'd20;
    frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    tick(21);
    rx = 1'b1;
    tick(21);
    rx = 1'b0;
    tick(10);
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    exp_q.delete();
    exp_ovr = 1'b0;
    check_reset_outputs("midrst");
    tick(3 * 21);
    check_status("midrst_idle");
    frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("after_rst");
    pop_check("after_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acia_rx_fifo.md
# acia_rx_fifo

Parametrised asynchronous serial receiver for the ACIA path. It extends the fixed 8N1 receiver with runtime baud divisor, 5–8 data bits, optional parity, break detection and a receive FIFO carrying per-byte error flags. It sits between the raw `rx_serial` pin and the ACIA register file, which pops bytes with `rd_stb`.

## Interface
- `SCW`, 16: width of baud divisor.
- `FAW`, 4: FIFO address width; depth = 2^FAW entries.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `rx_serial` in 1: raw asynchronous serial input, idle high.
- `baud_div` in SCW: clocks per bit minus 1 (115200 @ 16 MHz → 138); ≥15 required.
- `data_bits` in 2: 00=5, 01=6, 10=7, 11=8 data bits.
- `parity_en` in 1: expect parity bit after data.
- `parity_odd` in 1: 1=odd, 0=even parity.
- `rd_stb` in 1: pop head entry (ignored when empty).
- `rd_dat` out 8: head data, LSB-aligned, unused upper bits 0.
- `rd_fe` out 1: head entry framing error.
- `rd_pe` out 1: head entry parity error.
- `rd_valid` out 1: FIFO not empty.
- `fifo_cnt` out FAW+1: entries held, 0..2^FAW.
- `ovr` out 1: sticky overrun; cleared by reset or any accepted `rd_stb`.
- `brk` out 1: one-cycle pulse on break frame.

## Operation
- Input: 2-FF synchroniser, then hysteresis filter: `line` changes only after 4 consecutive agreeing synced samples; reset `line`=1.
- FSM states IDLE, START, DATA, PARITY, STOP. Bit counter `rcnt` (SCW bits) counts down; sample when 0, reload `baud_div`.
- IDLE: armed only after `line`=1 seen; on armed and `line`=0 → START, `rcnt`=`baud_div`>>1; latch `data_bits`, `parity_en`, `parity_odd` (mid-frame changes ignored).
- START: at sample, `line`=1 → false start, IDLE, no push; else DATA.
- DATA: shift `line` in LSB-first; after N bits → PARITY if latched parity_en else STOP.
- PARITY: pe = XOR(data bits, parity bit) ≠ parity_odd → STOP.
- STOP: fe = (`line`=0). Push {data, fe, pe} in this cycle; → IDLE, disarmed until `line`=1.
- Break: data all 0, parity bit 0 (if enabled), stop 0 → `brk` pulse with push; entry still stored (fe=1).
- FIFO: circular, pointers wrap at 2^FAW. Push when full and no pop: entry dropped, `ovr`←1. Push+pop same cycle when full: both done, no overrun, count unchanged. Pop when empty: no effect. `ovr` set and clear same cycle: set wins.

## Timing
- Reset: FSM IDLE disarmed-until-high, FIFO empty, `rd_valid`=0, `fifo_cnt`=0, `ovr`=0, `brk`=0, `rd_dat`/`rd_fe`/`rd_pe`=0 while empty.
- Start-to-push: filter+sync delay (6 clocks) + (`baud_div`>>1)+1 + (bits−1)·(`baud_div`+1) clocks for start..stop; push on stop-sample edge.
- `rd_valid`, `fifo_cnt` and head outputs update the cycle after push/pop.
- `brk` asserted the cycle after stop sample, 1 cycle wide.
- Reset mid-frame: frame discarded, no push, FIFO cleared.

## Configuration
- `ACIA_RXF_PARITY_EN` defined: PARITY state and pe checking built.
- Undefined: `parity_en`/`parity_odd` ignored, PARITY never entered, `rd_pe` always 0, break test omits parity bit.

## Test plan
- `baud_div`=138, 8N1, send 0xA5 → `rd_valid`, `rd_dat`=0xA5, fe=0, pe=0; `rd_stb` → `rd_valid`=0.
- 5-bit, even parity, send 0x1F with parity bit 0 → `rd_dat`=0x1F, `rd_pe`=1 (parity build).
- 8N1 frame with stop bit 0 (data 0x3C) → `rd_fe`=1, `brk`=0; line held low 20 bit times → one break entry, `brk` pulse once, no re-trigger until line high.
- 2-clock low glitch, then 4-bit-period low pulse shorter than half bit? use 40-clock pulse → no entry (false start rejected).
- FAW=2: send 5 bytes 0x01..0x05 without reads → `fifo_cnt`=4, `ovr`=1, reads 0x01..0x04; `ovr` cleared by first read.
- Full FIFO, `rd_stb` on push cycle → no overrun, `fifo_cnt` stays 4; `rst` mid-frame → no entry, all outputs at reset values.
